// File: rtl/imem_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_fetch_sequencer                                         |
// | Description : Fetch-stage PC owner; reads word-indexed IMEM into IF/ID,    |
// |               handles stall, redirect and end-of-program halt.             |
// |               Optional counters enabled by macro FETCH_STATS_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_fetch_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int IMEM_DEPTH = 7,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_next,
`ifdef FETCH_STATS_EN
    output logic              halted,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_bubbles
`else
    output logic              halted
`endif
);

    localparam logic [ADDR_W-1:0] c_DEPTH    = ADDR_W'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_ifpc;
    logic [ADDR_W-1:0] r_ifpcn;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_valid_nxt;
    logic [31:0]       w_instr_nxt;
    logic [ADDR_W-1:0] w_ifpc_nxt;
    logic [ADDR_W-1:0] w_ifpcn_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_adv;
    logic              w_bubble;

    assign w_pc_inc = r_pc + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_ifpc_nxt  = r_ifpc;
        w_ifpcn_nxt = r_ifpcn;
        w_adv       = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = (c_RESET_PC >= c_DEPTH) ? S_HALT : S_RUN;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = 32'd0;
                    w_bubble    = 1'b1;
                    if (redirect_pc >= c_DEPTH) begin
                        w_state_nxt = S_HALT;
                    end
                end else if (!stall) begin
                    w_adv       = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_instr_nxt = imem_instr;
                    w_ifpc_nxt  = r_pc;
                    w_ifpcn_nxt = w_pc_inc;
                    if (w_pc_inc == c_DEPTH) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (redirect_valid && (redirect_pc < c_DEPTH)) begin
                    w_pc_nxt    = redirect_pc;
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = 32'd0;
                    w_bubble    = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (!(stall && r_valid && !redirect_valid)) begin
                    // The last captured word survives only while decode is stalled on it.
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = 32'd0;
                    w_bubble    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= c_RESET_PC;
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_ifpc  <= '0;
            r_ifpcn <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_ifpc  <= w_ifpc_nxt;
            r_ifpcn <= w_ifpcn_nxt;
        end
    end

    assign imem_addr    = r_pc;
    assign ifid_valid   = r_valid;
    assign ifid_instr   = r_instr;
    assign ifid_pc      = r_ifpc;
    assign ifid_pc_next = r_ifpcn;
    assign halted       = (r_state == S_HALT);

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_bubbles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetched <= 32'd0;
            r_stat_bubbles <= 32'd0;
        end else begin
            if (w_adv && !(&r_stat_fetched)) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if (w_bubble && !(&r_stat_bubbles)) begin
                r_stat_bubbles <= r_stat_bubbles + 32'd1;
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_bubbles = r_stat_bubbles;
`else
    // Counters are absent in this build; advance/bubble strobes have no consumer.
    logic w_unused_strobes;
    assign w_unused_strobes = w_adv ^ w_bubble;
`endif

endmodule
`default_nettype wire
